// File: rtl/priority_scanner_if.sv
// rtl/priority_scanner_if.sv - load/scan handshake bundle for priority_scanner
interface priority_scanner_if;
    logic        load;
    logic [15:0] req;
    logic [3:0]  pos;
    logic        pos_valid;
    logic        pos_ready;
    logic        busy;
    logic        done;
    logic [15:0] pending;
    logic [4:0]  issued;

    modport master (
        output load, req, pos_ready,
        input  pos, pos_valid, busy, done, pending, issued
    );

    modport slave (
        input  load, req, pos_ready,
        output pos, pos_valid, busy, done, pending, issued
    );
endinterface

// File: rtl/priority_scanner.sv
// rtl/priority_scanner.sv - issues set bits of a captured request vector, highest first
module priority_scanner (
    input  logic                clk,
    input  logic                rst_n,
    priority_scanner_if.slave   ps
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pending_q;
    logic [15:0] pending_next;
    logic [4:0]  issued_q;
    logic [4:0]  issued_next;
    logic [3:0]  top_pos;

    // pending is never zero while scanning, so top_pos is always a real bit there
    always_comb begin
        top_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pending_q[i]) begin
                top_pos = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending_q;
        issued_next  = issued_q;
        case (state)
            ST_IDLE: begin
                if (ps.load) begin
                    pending_next = ps.req;
                    issued_next  = 5'd0;
                    state_next   = (ps.req != 16'd0) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (ps.pos_ready) begin
                    pending_next = pending_q & ~(16'd1 << top_pos);
                    issued_next  = issued_q + 5'd1;
                    if (pending_next == 16'd0) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 16'd0;
            issued_q  <= 5'd0;
        end else begin
            pending_q <= pending_next;
            issued_q  <= issued_next;
        end
    end

    assign ps.pos_valid = (state == ST_SCAN);
    assign ps.pos       = (state == ST_SCAN) ? top_pos : 4'd0;
    assign ps.busy      = (state != ST_IDLE);
    assign ps.done      = (state == ST_DONE);
    assign ps.pending   = pending_q;
    assign ps.issued    = issued_q;
endmodule

// File: doc/priority_scanner.md
PRIORITY_SCANNER -- requirements
Module: priority_scanner

Interface
REQ-001 Parameters: none; request width is fixed at 16 and position width at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  capture req into pending register when idle.
REQ-005 req  input  16  request vector; bit n set = request at position n.
REQ-006 pos  output  4  index of highest set bit of pending; 0 when pos_valid=0.
REQ-007 pos_valid  output  1  pos holds a valid position.
REQ-008 pos_ready  input  1  consumer accepts pos this cycle.
REQ-009 busy  output  1  scan in progress; load ignored.
REQ-010 done  output  1  one-cycle pulse when a scan finishes.
REQ-011 pending  output  16  requests not yet issued.
REQ-012 issued  output  5  positions issued since last accepted load, 0..16.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-014 IDLE, load=1, req!=0: pending<=req, issued<=0, next state SCAN.
REQ-015 IDLE, load=1, req==0: pending<=0, issued<=0, next state DONE; no position is issued (an all-zero vector never produces position 15).
REQ-016 IDLE, load=0: hold all state.
REQ-017 SCAN: pos_valid=1 and pos=highest set bit index of pending, combinational from the pending register; first pos_valid one cycle after the load edge.
REQ-018 Transfer = pos_valid & pos_ready in the same cycle; pos and pending SHALL stay stable while pos_valid=1 and pos_ready=0.
REQ-019 On transfer: clear bit pos in pending, issued<=issued+1; if the cleared bit was the last set bit, go to DONE, else stay in SCAN.
REQ-020 Back-to-back transfers SHALL sustain one position per cycle, in strictly descending position order.
REQ-021 DONE: done=1 for exactly one cycle, pos_valid=0; next state IDLE unconditionally.
REQ-022 busy=1 in SCAN and DONE, 0 in IDLE; load while busy=1 SHALL be ignored with no effect on pending or issued.
REQ-023 issued SHALL saturate-free count to 16 max (16 bits set); it holds its value through DONE and IDLE until the next accepted load.
REQ-024 pos_ready while pos_valid=0 SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately, without clock, force state=IDLE, pending=0, issued=0, pos=0, pos_valid=0, busy=0, done=0.
REQ-026 Reset asserted mid-scan SHALL abandon the scan; no done pulse; first accepted load after rst_n deassert starts fresh.

Verification
REQ-027 Load 16'h8421, pos_ready=1 constant -> pos 15,10,5,0 on consecutive cycles, done pulse next cycle, issued=4.
REQ-028 Load 16'hFFFF, pos_ready=1 -> 16 consecutive positions 15..0, issued=16, done once, busy low after.
REQ-029 Load 16'h0000 -> no pos_valid, done pulse one cycle after load, issued=0.
REQ-030 Load 16'h0012, pos_ready low 3 cycles -> pos=4 held stable, pending=16'h0012; then ready -> 4, 1, done.
REQ-031 Load 16'h0003, second load 16'hF000 during SCAN -> ignored; output 1, 0 only.
REQ-032 Load 16'h0F00, assert rst_n=0 after first transfer -> all outputs zero immediately, no done; reload 16'h0001 -> pos 0, done.
